// File: rtl/digit_entry_sequencer.sv
// ============================================================================
// Module   : digit_entry_sequencer
// Purpose  : Debounces the enter button and delivers one validated BCD digit
//            plus a ready strobe per press to the Caesar encoder.
// Options  : define AUTO_REPEAT_EN to re-issue the digit while the button is held
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_entry_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int READY_HIGH      = 2,
    parameter int REPEAT_CYCLES   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       btn,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       ready,
    output logic       err,
    output logic       busy,
    output logic [3:0] digit_count
);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_DEBOUNCE     = 3'd1,
        ST_STROBE_SETUP = 3'd2,
        ST_STROBE       = 3'd3,
        ST_RELEASE      = 3'd4
    } state_t;

    localparam logic [7:0] c_db_last  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] c_rdy_last = 8'(READY_HIGH - 1);

    state_t     state_q, state_d;
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] digit_q, digit_d;
    logic       ready_q, ready_d;
    logic       err_q, err_d;
    logic [3:0] count_q, count_d;
    logic       w_btn_s;
    logic       w_sw_valid;

`ifdef AUTO_REPEAT_EN
    localparam logic [15:0] c_rep_last = 16'(REPEAT_CYCLES - 1);
    logic [15:0] rep_q, rep_d;
`else
    logic w_unused_repeat;
    assign w_unused_repeat = (REPEAT_CYCLES == 0);
`endif

    assign w_btn_s    = sync2_q;
    assign w_sw_valid = (sw <= 4'd9);

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        ready_d = ready_q;
        err_d   = err_q;
        count_d = count_q;
`ifdef AUTO_REPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_btn_s) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = 8'd0;
                end
            end
            ST_DEBOUNCE: begin
                if (!w_btn_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == c_db_last) begin
                    cnt_d = 8'd0;
`ifdef AUTO_REPEAT_EN
                    rep_d = 16'd0;
`endif
                    if (w_sw_valid) begin
                        digit_d = sw;
                        err_d   = 1'b0;
                        state_d = ST_STROBE_SETUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_STROBE_SETUP: begin
                ready_d = 1'b1;
                count_d = count_q + 4'd1;
                state_d = ST_STROBE;
                cnt_d   = 8'd0;
            end
            ST_STROBE: begin
                if (cnt_q == c_rdy_last) begin
                    ready_d = 1'b0;
                    state_d = ST_RELEASE;
                    cnt_d   = 8'd0;
`ifdef AUTO_REPEAT_EN
                    rep_d   = 16'd0;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RELEASE: begin
                if (w_btn_s) begin
                    cnt_d = 8'd0;
`ifdef AUTO_REPEAT_EN
                    // Held long enough: treat as a fresh press of the same digit
                    if (rep_q == c_rep_last) begin
                        rep_d = 16'd0;
                        if (w_sw_valid) begin
                            digit_d = sw;
                            err_d   = 1'b0;
                            state_d = ST_STROBE_SETUP;
                        end else begin
                            err_d   = 1'b1;
                        end
                    end else begin
                        rep_d = rep_q + 16'd1;
                    end
`endif
                end else begin
`ifdef AUTO_REPEAT_EN
                    rep_d = 16'd0;
`endif
                    if (cnt_q == c_db_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= 8'd0;
            digit_q <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= 4'd0;
`ifdef AUTO_REPEAT_EN
            rep_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            count_q <= count_d;
`ifdef AUTO_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign {a, b, c, d} = digit_q;
    assign ready        = ready_q;
    assign err          = err_q;
    assign busy         = (state_q != ST_IDLE);
    assign digit_count  = count_q;

endmodule

`default_nettype wire
